// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD countdown timer.
//   state_t   : controller states (IDLE is the reset state)
//   BCD_MAX   : largest legal BCD digit value
//   bcd_valid : true when a 4-bit digit holds a legal BCD value (0..9)
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic bcd_valid(input logic [3:0] digit);
      return (digit <= BCD_MAX);
   endfunction

endpackage

// File: rtl/decade_down_digit.sv
// One BCD digit of the countdown timer.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, clears digit to 0
//   load       in   load load_digit (takes priority over dec)
//   load_digit in   [3:0] digit value to load
//   dec        in   decrement by one, 0 wraps to 9 (borrow out)
//   digit      out  [3:0] current digit value
//   is_zero    out  digit currently equals 0
module decade_down_digit
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_digit,
   input  logic       dec,
   output logic [3:0] digit,
   output logic       is_zero
);

   always_ff @(posedge clk) begin
      if (rst) begin
         digit <= 4'd0;
      end else if (load) begin
         digit <= load_digit;
      end else if (dec) begin
         digit <= (digit == 4'd0) ? BCD_MAX : (digit - 4'd1);
      end
   end

   assign is_zero = (digit == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with preset load, start/pause control and a
// one-cycle terminal-count pulse. Decrements are paced by the tick strobe.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   load     in   preset strobe (rejected with err if any digit > 9)
//   load_val in   [4*DIGITS-1:0] BCD preset, digit 0 in bits [3:0]
//   start    in   start / resume strobe
//   pause    in   pause strobe (RUN only)
//   tick     in   decrement enable, honoured only in RUN
//   count    out  [4*DIGITS-1:0] current BCD value
//   busy     out  high in RUN or PAUSED
//   done     out  one-cycle pulse on terminal count or start-at-zero
//   err      out  one-cycle pulse when a load is rejected
module bcd_countdown_timer
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  tick,
   output logic [4*DIGITS-1:0]   count,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   state_t              state;
   logic                load_ok;
   logic                dec_en;
   logic                count_zero;
   logic                count_is_one;
   logic [DIGITS-1:0]   is_zero;
   logic [DIGITS-1:0]   dec;

   always_comb begin
      load_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (!bcd_valid(load_val[4*i +: 4])) load_ok = 1'b0;
      end
   end

   assign count_zero   = &is_zero;
   assign count_is_one = (count == (4*DIGITS)'(1));

   // Any load (accepted or rejected) blocks decrementing; pause beats tick.
   // The count_zero guard keeps the counter from ever wrapping to all-9s.
   assign dec_en = (state == RUN) && tick && !pause && !load && !count_zero;

   // Digit i borrows only when every lower digit is already zero.
   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      if (i == 0) begin : g_lsd
         assign dec[i] = dec_en;
      end else begin : g_upper
         assign dec[i] = dec_en && (&is_zero[i-1:0]);
      end

      decade_down_digit u_digit (
         .clk        (clk),
         .rst        (rst),
         .load       (load && load_ok),
         .load_digit (load_val[4*i +: 4]),
         .dec        (dec[i]),
         .digit      (count[4*i +: 4]),
         .is_zero    (is_zero[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (load) begin
            if (load_ok) state <= IDLE;
            else         err   <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (count_zero) done  <= 1'b1;
                     else            state <= RUN;
                  end
               end
               RUN: begin
                  if (pause) begin
                     state <= PAUSED;
                  end else if (tick && count_is_one) begin
                     // This tick takes the count to zero.
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
               PAUSED: begin
                  if (start) state <= RUN;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
module tb_bcd_countdown_timer;

   localparam int D  = 2;
   localparam int W  = 4 * D;
   localparam int EW = W + 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          load = 1'b0;
   logic [W-1:0]  load_val = '0;
   logic          start = 1'b0;
   logic          pause = 1'b0;
   logic          tick = 1'b0;
   logic [W-1:0]  count;
   logic          busy;
   logic          done;
   logic          err;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   // expected {count, busy, done, err} after each clock edge
   logic [EW-1:0] exp_q[$];

   // reference model: decimal value plus a simple mode number
   int m_val  = 0;
   int m_mode = 0;   // 0 idle, 1 running, 2 paused

   bcd_countdown_timer #(.DIGITS(D)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .pause    (pause),
      .tick     (tick),
      .count    (count),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   // clock
   always #5 clk = ~clk;

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int from_bcd(input logic [W-1:0] b);
      int v;
      v = 0;
      for (int i = D - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
      return v;
   endfunction

   function automatic logic all_legal(input logic [W-1:0] b);
      for (int i = 0; i < D; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   // drive one cycle of inputs, advance the model, queue the expectation
   task automatic step(input logic r, input logic l, input logic [W-1:0] lv,
                       input logic s, input logic p, input logic t);
      logic m_done, m_err;
      rst = r; load = l; load_val = lv; start = s; pause = p; tick = t;
      m_done = 1'b0;
      m_err  = 1'b0;
      if (r) begin
         m_val  = 0;
         m_mode = 0;
      end else if (l) begin
         if (all_legal(lv)) begin
            m_val  = from_bcd(lv);
            m_mode = 0;
         end else begin
            m_err = 1'b1;
         end
      end else if (m_mode == 0) begin
         if (s) begin
            if (m_val == 0) m_done = 1'b1;
            else            m_mode = 1;
         end
      end else if (m_mode == 1) begin
         if (p) begin
            m_mode = 2;
         end else if (t) begin
            m_val = m_val - 1;
            if (m_val == 0) begin
               m_mode = 0;
               m_done = 1'b1;
            end
         end
      end else begin
         if (s) m_mode = 1;
      end
      exp_q.push_back({to_bcd(m_val), (m_mode != 0), m_done, m_err});
      @(negedge clk);
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0);
   endtask

   task automatic ld(input logic [W-1:0] v);
      step(0, 1, v, 0, 0, 0);
   endtask

   task automatic go();
      step(0, 0, '0, 1, 0, 0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 1);
   endtask

   // monitor / scoreboard
   always @(posedge clk) begin
      logic [EW-1:0] e;
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if ({count, busy, done, err} !== e) begin
            errors++;
            $display("FAIL cycle %0d outputs: count=%h busy=%b done=%b err=%b, expected count=%h busy=%b done=%b err=%b",
                     cycle, count, busy, done, err, e[EW-1:3], e[2], e[1], e[0]);
         end
      end
   end

   initial begin
      int sel;
      logic [W-1:0] v;

      // reset
      step(1, 0, '0, 0, 0, 0);
      step(1, 0, '0, 0, 0, 0);
      idle_n(2);

      // reset mid-run at 37
      ld(8'h40); go(); ticks(3);
      step(1, 0, '0, 0, 0, 1);
      step(1, 0, '0, 0, 0, 1);
      ticks(2);

      // borrow chain 20 -> 0, then extra ticks stay at zero
      ld(8'h20); go(); ticks(20); ticks(3);

      // pause and resume
      ld(8'h05); go(); ticks(2);
      step(0, 0, '0, 0, 1, 1);
      ticks(3);
      go();
      ticks(3);
      idle_n(1);

      // invalid load keeps value, valid load follows
      ld(8'h42); ld(8'h3A); idle_n(1); ld(8'h09); idle_n(1);
      // invalid load while running leaves the run untouched
      go(); ticks(1); step(0, 1, 8'hA1, 0, 0, 1); ticks(1);

      // start at zero
      ld(8'h00); go(); idle_n(2);

      // load aborts a run
      ld(8'h50); go(); ticks(3);
      step(0, 1, 8'h12, 0, 0, 1);
      idle_n(2);

      // start+pause together
      ld(8'h03); step(0, 0, '0, 1, 1, 0);
      step(0, 0, '0, 1, 1, 1);
      step(0, 0, '0, 1, 1, 0);
      ticks(4);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         sel = $urandom_range(0, 199);
         if (sel == 0) begin
            step(1, 0, '0, 0, 0, $urandom_range(0, 1));
         end else if (sel < 12) begin
            if ($urandom_range(0, 3) == 0) v = W'($urandom());
            else v = to_bcd($urandom_range(0, 12));
            step(0, 1, v, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
         end else begin
            step(0, 0, W'($urandom()), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0));
         end
      end

      idle_n(1);
      // bounded drain of the scoreboard
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
